// File: rtl/fetch_unit.sv
// RV64I fetch stage: owns the PC, drives the instruction bus, and hands a
// registered {raw_instr, pc, valid} bundle to decode.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FULL
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [63:0] kill_pc_q, kill_pc_d;
    fetch_data_t out_q, out_d;

    logic        req;
    logic        arrive;
    logic [63:0] target;

    assign target = {redirect_pc[63:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        kill_pc_d = kill_pc_q;
        out_d     = out_q;
        req       = 1'b0;
        arrive    = 1'b0;

        unique case (state_q)
            REQ: begin
                req    = 1'b1;
                arrive = iresp_addr_ok & iresp_data_ok;
                if (iresp_addr_ok && !iresp_data_ok)
                    state_d = WAIT;
            end
            WAIT: begin
                arrive = iresp_data_ok;
            end
            FULL: begin
                if (redirect_valid) begin
                    out_d.valid = 1'b0;
                    pc_d        = target;
                    state_d     = REQ;
                end else if (!stallF) begin
                    out_d.valid = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // A redirect seen before the data returns poisons the in-flight fetch
        if (arrive) begin
            if (kill_q || redirect_valid) begin
                pc_d    = redirect_valid ? target : kill_pc_q;
                kill_d  = 1'b0;
                state_d = REQ;
            end else begin
                out_d   = '{raw_instr: iresp_data, pc: pc_q, valid: 1'b1};
                pc_d    = pc_q + 64'd4;
                state_d = FULL;
            end
        end else if (state_q != FULL && redirect_valid) begin
            kill_d    = 1'b1;
            kill_pc_d = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= REQ;
            pc_q      <= {PCINIT[63:2], 2'b00};
            kill_q    <= 1'b0;
            kill_pc_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            kill_pc_q <= kill_pc_d;
            out_q     <= out_d;
        end
    end

    assign ireq_valid = req & ~reset;
    assign ireq_addr  = {pc_q[63:2], 2'b00};
    assign dataF      = out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model
// checked every cycle plus literal expectations on key points.
module tb_fetch_unit;

    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stallF;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [96:0] dataF;

    fetch_unit #(.PCINIT(PCINIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .stallF        (stallF),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dataF         (dataF)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: what the front end has promised so far
    logic [63:0] m_pc;
    logic        m_busy;
    logic        m_full;
    logic        m_kill;
    logic [63:0] m_kill_pc;
    logic [31:0] m_instr;
    logic [63:0] m_opc;
    logic        m_valid;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc      = PCINIT;
        m_busy    = 1'b0;
        m_full    = 1'b0;
        m_kill    = 1'b0;
        m_kill_pc = '0;
        m_instr   = '0;
        m_opc     = '0;
        m_valid   = 1'b0;
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        logic        got;
        tgt = {redirect_pc[63:2], 2'b00};
        if (m_full) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_full  = 1'b0;
                m_pc    = tgt;
            end else if (!stallF) begin
                m_valid = 1'b0;
                m_full  = 1'b0;
            end
        end else begin
            got = m_busy ? iresp_data_ok : (iresp_addr_ok && iresp_data_ok);
            if (got) begin
                m_busy = 1'b0;
                if (m_kill || redirect_valid) begin
                    m_pc   = redirect_valid ? tgt : m_kill_pc;
                    m_kill = 1'b0;
                end else begin
                    m_instr = iresp_data;
                    m_opc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 64'd4;
                    m_full  = 1'b1;
                end
            end else begin
                if (!m_busy && iresp_addr_ok) m_busy = 1'b1;
                if (redirect_valid) begin
                    m_kill    = 1'b1;
                    m_kill_pc = tgt;
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, then advance the model
    task automatic tick();
        @(negedge clk);
        if (reset) model_reset();
        chk("ireq_valid", 128'(ireq_valid),
            128'(!reset && !m_full && !m_busy));
        chk("ireq_addr", 128'(ireq_addr), 128'(m_pc));
        chk("dataF", 128'(dataF), 128'({m_instr, m_opc, m_valid}));
        if (!reset) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        stallF         = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        iresp_data  = '0;
        redirect_pc = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dataF", 128'(dataF), 128'(0));
        chk("rst_ireq_valid", 128'(ireq_valid), 128'(0));
        tick();
        reset = 1'b0;
        #1;
        chk("rel_ireq_valid", 128'(ireq_valid), 128'(1));
        chk("rel_addr", 128'(ireq_addr), 128'(64'h8000_0000));

        // Same-cycle accept and data
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        tick();
        idle();
        chk("s1_dataF", 128'(dataF),
            128'({32'h0000_0013, 64'h8000_0000, 1'b1}));
        tick();
        chk("s1_next_addr", 128'(ireq_addr), 128'(64'h8000_0004));
        chk("s1_next_req", 128'(ireq_valid), 128'(1));

        // Accept now, data three cycles later
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("s2_no_req", 128'(ireq_valid), 128'(0));
            tick();
        end
        chk("s2_no_req_last", 128'(ireq_valid), 128'(0));
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0010_0093;
        tick();
        idle();
        chk("s2_dataF", 128'(dataF),
            128'({32'h0010_0093, 64'h8000_0004, 1'b1}));

        // Back-pressure holds the bundle
        stallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s3_hold", 128'(dataF),
                128'({32'h0010_0093, 64'h8000_0004, 1'b1}));
            chk("s3_no_req", 128'(ireq_valid), 128'(0));
        end
        stallF = 1'b0;
        tick();
        chk("s3_next_addr", 128'(ireq_addr), 128'(64'h8000_0008));
        chk("s3_cleared", 128'(dataF[0]), 128'(0));

        // Redirect during WAIT drops the returning word
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        tick();
        idle();
        tick();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        tick();
        idle();
        chk("s4_dropped", 128'(dataF[0]), 128'(0));
        chk("s4_addr", 128'(ireq_addr), 128'(64'h8000_1000));

        // Two redirects in WAIT: last one wins
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_pc    = 64'h200;
        tick();
        idle();
        iresp_data_ok = 1'b1;
        tick();
        idle();
        chk("s5_addr", 128'(ireq_addr), 128'(64'h200));
        chk("s5_dropped", 128'(dataF[0]), 128'(0));

        // Redirect coincident with data return
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        iresp_data_ok  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        tick();
        idle();
        chk("s5b_addr", 128'(ireq_addr), 128'(64'h300));
        chk("s5b_dropped", 128'(dataF[0]), 128'(0));

        // Redirect while FULL and stalled
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_AAAA;
        tick();
        idle();
        chk("s6_dataF", 128'(dataF),
            128'({32'h0000_AAAA, 64'h300, 1'b1}));
        stallF = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        tick();
        idle();
        chk("s6_cleared", 128'(dataF[0]), 128'(0));
        chk("s6_addr", 128'(ireq_addr), 128'(64'h8000_2000));

        // Reset in the middle of WAIT, then a stray data_ok
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        tick();
        reset = 1'b1;
        #1;
        chk("s7_rst_dataF", 128'(dataF), 128'(0));
        chk("s7_rst_req", 128'(ireq_valid), 128'(0));
        tick();
        reset         = 1'b0;
        iresp_data_ok = 1'b1;
        tick();
        idle();
        chk("s7_addr", 128'(ireq_addr), 128'(PCINIT));
        chk("s7_ignored", 128'(dataF[0]), 128'(0));

        // PC wraps past the top of the address space
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h1234_5678;
        tick();
        idle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle();
        chk("s8_addr", 128'(ireq_addr), 128'(64'hFFFF_FFFF_FFFF_FFFC));
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0067;
        tick();
        idle();
        chk("s8_dataF", 128'(dataF),
            128'({32'h0000_0067, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1}));
        tick();
        chk("s8_wrap", 128'(ireq_addr), 128'(64'h0));
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
